// File: rtl/pong_renderer.sv
// pong_renderer: once per accepted frame tick, erases the old ball and paddles
// and redraws them at their snapshotted positions, one VGA pixel per cycle.
module pong_renderer #(
  parameter int PADDLE_H = 21,
  parameter int BALL_SIZE = 2,
  parameter logic [2:0] BG_COLOUR = 3'b000,
  parameter logic [2:0] PADDLE_COLOUR = 3'b111,
  parameter logic [2:0] BALL_COLOUR = 3'b110
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic [7:0] ball_x,
  input  logic [6:0] ball_y,
  input  logic [7:0] p1_x,
  input  logic [6:0] p1_y,
  input  logic [7:0] p2_x,
  input  logic [6:0] p2_y,
  output logic [7:0] vga_x,
  output logic [6:0] vga_y,
  output logic [2:0] vga_colour,
  output logic       vga_plot,
  output logic       busy,
  output logic [7:0] dropped_frames
);
  localparam int BALL_N = BALL_SIZE * BALL_SIZE;
  localparam int KW = $clog2((PADDLE_H > BALL_N ? PADDLE_H : BALL_N) + 1);
  typedef enum logic [2:0] {IDLE, ERASE_BALL, ERASE_P1, ERASE_P2, DRAW_P1, DRAW_P2, DRAW_BALL} state_t;
  state_t state;
  logic [KW-1:0] k, off_x, off_y;
  logic first_frame, erase, is_ball, is_p1, clip, last;
  logic [7:0] ob_x, op1_x, op2_x, nb_x, np1_x, np2_x, obj_x;
  logic [6:0] ob_y, op1_y, op2_y, nb_y, np1_y, np2_y, obj_y;
  logic [8:0] sx;
  logic [7:0] sy;
  always_comb begin
    erase = state inside {ERASE_BALL, ERASE_P1, ERASE_P2};
    is_ball = state inside {ERASE_BALL, DRAW_BALL};
    is_p1 = state inside {ERASE_P1, DRAW_P1};
    obj_x = is_ball ? (erase ? ob_x : nb_x) : is_p1 ? (erase ? op1_x : np1_x) : (erase ? op2_x : np2_x);
    obj_y = is_ball ? (erase ? ob_y : nb_y) : is_p1 ? (erase ? op1_y : np1_y) : (erase ? op2_y : np2_y);
    off_x = is_ball ? KW'(k % BALL_SIZE) : '0;
    off_y = is_ball ? KW'(k / BALL_SIZE) : k;
    sx = {1'b0, obj_x} + 9'(off_x);
    sy = {1'b0, obj_y} + 8'(off_y);
    clip = sx > 9'd159 || sy > 8'd119;
    last = k == (is_ball ? KW'(BALL_N - 1) : KW'(PADDLE_H - 1));
  end
  // Off-screen sums saturate so a clipped address can never alias a visible pixel.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      k <= '0;
      first_frame <= 1'b1;
      busy <= 1'b0;
      dropped_frames <= '0;
      vga_x <= '0;
      vga_y <= '0;
      vga_colour <= '0;
      vga_plot <= 1'b0;
      {ob_x, ob_y, op1_x, op1_y, op2_x, op2_y} <= '0;
      {nb_x, nb_y, np1_x, np1_y, np2_x, np2_y} <= '0;
    end else begin
      vga_plot <= state != IDLE && !clip;
      vga_x <= sx[8] ? 8'hff : sx[7:0];
      vga_y <= sy[7] ? 7'h7f : sy[6:0];
      vga_colour <= erase ? BG_COLOUR : is_ball ? BALL_COLOUR : PADDLE_COLOUR;
      if (frame_tick && busy && dropped_frames != 8'hff) dropped_frames <= dropped_frames + 8'd1;
      case (state)
        IDLE: if (frame_tick) begin
          {nb_x, nb_y, np1_x, np1_y, np2_x, np2_y} <= {ball_x, ball_y, p1_x, p1_y, p2_x, p2_y};
          k <= '0;
          busy <= 1'b1;
          state <= first_frame ? DRAW_P1 : ERASE_BALL;
        end
        default: if (!last) k <= k + KW'(1);
        else begin
          k <= '0;
          if (state == DRAW_BALL) begin
            {ob_x, ob_y, op1_x, op1_y, op2_x, op2_y} <= {nb_x, nb_y, np1_x, np1_y, np2_x, np2_y};
            first_frame <= 1'b0;
            busy <= 1'b0;
            state <= IDLE;
          end else state <= state_t'(state + 3'd1);
        end
      endcase
    end
  end
endmodule

// File: tb/tb_pong_renderer.sv
// tb_pong_renderer: directed frame sequences against hand-computed pixel lists.
module tb_pong_renderer;
  logic clk = 0, reset = 1, frame_tick = 0;
  logic [7:0] ball_x = 0, p1_x = 0, p2_x = 0, vga_x, dropped_frames;
  logic [6:0] ball_y = 0, p1_y = 0, p2_y = 0, vga_y;
  logic [2:0] vga_colour;
  logic vga_plot, busy;
  int errors = 0, checks = 0, busy_cnt = 0, first_at;
  logic [17:0] plots[$];

  pong_renderer dut (
    .clk(clk), .reset(reset), .frame_tick(frame_tick),
    .ball_x(ball_x), .ball_y(ball_y), .p1_x(p1_x), .p1_y(p1_y), .p2_x(p2_x), .p2_y(p2_y),
    .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour), .vga_plot(vga_plot),
    .busy(busy), .dropped_frames(dropped_frames)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (vga_plot) plots.push_back({vga_x, vga_y, vga_colour});
    if (busy) busy_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pix(input int i, input logic [7:0] x, input logic [6:0] y, input logic [2:0] c);
    chk($sformatf("pix%0d", i), 32'(i < plots.size() ? plots[i] : 18'h3ffff), {14'd0, x, y, c});
  endtask

  task automatic set_pos(input logic [7:0] bx, input logic [6:0] by, input logic [7:0] ax,
                         input logic [6:0] ay, input logic [7:0] cx, input logic [6:0] cy);
    ball_x = bx; ball_y = by; p1_x = ax; p1_y = ay; p2_x = cx; p2_y = cy;
  endtask

  // One tick, then a fixed 120-cycle window; optional second tick and ball_x change.
  task automatic frame(input int t2, input int chg, input logic [7:0] chg_x);
    plots.delete();
    busy_cnt = 0;
    first_at = -1;
    @(negedge clk) frame_tick = 1;
    for (int c = 1; c <= 120; c++) begin
      @(negedge clk);
      if (vga_plot && first_at < 0) first_at = c;
      frame_tick = (c == t2);
      if (c == chg) ball_x = chg_x;
    end
    chk("idle_after_frame", busy, 0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_plot", vga_plot, 0);
    chk("rst_busy", busy, 0);
    chk("rst_drop", dropped_frames, 0);
    chk("rst_xyc", {vga_x, vga_y, vga_colour}, 0);
    reset = 0;
    set_pos(80, 75, 5, 50, 154, 50);
    frame(0, 0, 0);
    chk("f1_count", plots.size(), 46);
    chk("f1_busy", busy_cnt, 46);
    chk("f1_latency", first_at, 2);
    pix(0, 5, 50, 7); pix(20, 5, 70, 7); pix(21, 154, 50, 7); pix(41, 154, 70, 7);
    pix(42, 80, 75, 6); pix(43, 81, 75, 6); pix(44, 80, 76, 6); pix(45, 81, 76, 6);

    set_pos(81, 76, 5, 50, 154, 50);
    frame(0, 0, 0);
    chk("f2_count", plots.size(), 92);
    chk("f2_busy", busy_cnt, 92);
    pix(0, 80, 75, 0); pix(1, 81, 75, 0); pix(2, 80, 76, 0); pix(3, 81, 76, 0);
    pix(4, 5, 50, 0);
    pix(88, 81, 76, 6); pix(89, 82, 76, 6); pix(90, 81, 77, 6); pix(91, 82, 77, 6);

    set_pos(159, 119, 5, 50, 154, 50);
    frame(0, 0, 0);
    chk("clip_count", plots.size(), 89);
    chk("clip_busy", busy_cnt, 92);
    pix(87, 154, 70, 7); pix(88, 159, 119, 6);

    set_pos(100, 60, 5, 50, 154, 50);
    frame(10, 20, 10);
    chk("drop_one", dropped_frames, 1);
    chk("drop_count", plots.size(), 89);
    chk("drop_busy", busy_cnt, 92);
    pix(0, 159, 119, 0);
    pix(85, 100, 60, 6); pix(86, 101, 60, 6); pix(87, 100, 61, 6); pix(88, 101, 61, 6);

    @(negedge clk) frame_tick = 1;
    repeat (350) @(negedge clk);
    frame_tick = 0;
    repeat (120) @(negedge clk);
    chk("drop_sat", dropped_frames, 255);
    chk("sat_idle", busy, 0);

    plots.delete();
    @(negedge clk) frame_tick = 1;
    @(negedge clk) frame_tick = 0;
    repeat (29) @(negedge clk);
    chk("mid_plotting", vga_plot, 1);
    reset = 1;
    #1;
    chk("mid_rst_plot", vga_plot, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_drop", dropped_frames, 0);
    @(negedge clk) reset = 0;
    set_pos(20, 30, 5, 10, 154, 10);
    frame(0, 0, 0);
    chk("post_rst_count", plots.size(), 46);
    chk("post_rst_busy", busy_cnt, 46);
    pix(0, 5, 10, 7); pix(45, 21, 31, 6);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/pong_renderer.md
PONG_RENDERER -- requirements
Module: pong_renderer

Interface
REQ-001 Parameter PADDLE_H, default 21: paddle height in pixels; rows p_y .. p_y+PADDLE_H-1.
REQ-002 Parameter BALL_SIZE, default 2: ball is a BALL_SIZE x BALL_SIZE square with its top-left corner at (ball_x, ball_y).
REQ-003 Parameters BG_COLOUR 3'b000, PADDLE_COLOUR 3'b111, BALL_COLOUR 3'b110: plotted colours.
REQ-004 clk  in  1  single system clock; all logic is on its rising edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 frame_tick  in  1  one-cycle pulse in the clk domain, once per 60 Hz frame.
REQ-007 ball_x  in  8, ball_y  in  7  current ball position from the ball stage.
REQ-008 p1_x, p2_x  in  8; p1_y, p2_y  in  7  current left and right paddle top-left positions.
REQ-009 vga_x  out  8, vga_y  out  7, vga_colour  out  3  pixel write address and data to the VGA adapter.
REQ-010 vga_plot  out  1  write strobe; one pixel is written per cycle in which it is high.
REQ-011 busy  out  1  high while a frame update sequence is in progress.
REQ-012 dropped_frames  out  8  saturating count of frame_tick pulses ignored while busy.

Function
REQ-013 The FSM SHALL have these states, in order: IDLE, ERASE_BALL, ERASE_P1, ERASE_P2, DRAW_P1, DRAW_P2, DRAW_BALL.
REQ-014 In IDLE, frame_tick=1 SHALL snapshot ball_x, ball_y, p1_*, p2_* into "new" registers. The next state is ERASE_BALL, or DRAW_P1 if first_frame=1.
REQ-015 Inputs SHALL NOT be sampled except at the IDLE snapshot; changes during busy have no effect on the current sequence.
REQ-016 Each non-IDLE state SHALL last exactly N cycles, using a pixel counter k that starts at 0 on state entry. N=PADDLE_H for paddle states and BALL_SIZE^2 for ball states.
REQ-017 Paddle states SHALL output vga_x=p_x and vga_y=p_y+k, in top-to-bottom order.
REQ-018 Ball states SHALL output pixels in raster order: vga_x=x+(k mod BALL_SIZE), vga_y=y+(k div BALL_SIZE).
REQ-019 Erase states SHALL use the "old" registers with BG_COLOUR. Draw states SHALL use the "new" registers with PADDLE_COLOUR or BALL_COLOUR.
REQ-020 Address sums SHALL be computed one bit wider than the operand. A pixel with x>159 or y>119 SHALL have vga_plot=0, but its cycle is still consumed. Address outputs never wrap onto the visible screen.
REQ-021 vga_plot SHALL be 1 in every non-IDLE cycle not clipped by REQ-020, and 0 in IDLE.
REQ-022 vga_x, vga_y, vga_colour and vga_plot SHALL be registered. The first plot appears 2 cycles after the frame_tick cycle.
REQ-023 On the last DRAW_BALL cycle, the FSM SHALL copy the new registers into the old registers, clear first_frame, and return to IDLE.
REQ-024 busy SHALL be 1 from the cycle after the accepted tick through the last plotted pixel, then 0.
REQ-025 A full sequence SHALL be 92 plot cycles (4+21+21+21+21+4), or 46 on the first frame.
REQ-026 frame_tick while busy SHALL be ignored and SHALL increment dropped_frames, which saturates at 255.
REQ-027 A frame_tick arriving in the same cycle the FSM returns to IDLE SHALL be dropped. A tick in the following IDLE cycle SHALL be accepted.
REQ-028 Overlapping objects SHALL be handled by ordering only: later writes overwrite earlier ones, so the ball wins over paddles.

Reset
REQ-029 reset SHALL immediately force: state IDLE, vga_x=0, vga_y=0, vga_colour=0, vga_plot=0, busy=0, dropped_frames=0, first_frame=1, and all old/new registers=0.
REQ-030 reset asserted mid-sequence SHALL abort the sequence with no further plots. The next accepted tick SHALL run a first-frame sequence with no erase.

Verification
REQ-031 First frame: reset, ball=(80,75), p1=(5,50), p2=(154,50), one tick.
  - Expect 46 plots: (5,50..70) and (154,50..70) with 111, then (80,75),(81,75),(80,76),(81,76) with 110.
  - busy high for 46 cycles.
REQ-032 Second frame: ball moves to (81,76), same paddles, tick.
  - First 4 plots erase (80,75),(81,75),(80,76),(81,76) with 000.
  - Last 4 plots draw (81,76),(82,76),(81,77),(82,77).
  - Total 92 plots.
REQ-033 Clipping: ball=(159,119), tick.
  - Only (159,119) is plotted among the ball pixels.
  - The 3 clipped cycles keep vga_plot=0, and sequence length is unchanged.
REQ-034 Tick while busy: second tick 10 cycles after the first.
  - dropped_frames=1, and the sequence is unaffected.
  - 300 dropped ticks leave dropped_frames=255.
REQ-035 Input change mid-sequence: change ball_x 20 cycles after the tick.
  - Plotted ball pixels use the snapshot value.
REQ-036 Reset mid-sequence: assert reset 30 cycles into the 92-cycle sequence.
  - vga_plot=0 immediately.
  - The next tick produces 46 plots with no erase.
